// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg
//   Shared types and constants for the branch target buffer slice.
//   WORD_SIZE       : instruction/address width of the CPU
//   BTB_INDEX_BITS  : default log2 of the table depth
//   btb_state_e     : table lifecycle (INIT clears entries, READY predicts)
//   CTR_*           : 2-bit direction counter encodings used on allocation
package branch_target_buffer_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int BTB_INDEX_BITS = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } btb_state_e;

  localparam logic [1:0] CTR_WEAK_TAKEN   = 2'd2;
  localparam logic [1:0] CTR_STRONG_TAKEN = 2'd3;

endpackage

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if
//   Bundles the fetch-side lookup and the EX-side training port.
//   master : CPU pipeline (drives fetch_pc and upd_*, receives predictions)
//   slave  : branch_target_buffer
//
//   Handshake: upd_valid is a single-cycle strobe with no ready. Every
//   report presented while the table is READY is consumed at that posedge;
//   reports presented while busy=1 are dropped. upd_mispredict is only
//   meaningful together with upd_valid.
interface branch_target_buffer_if;
  import branch_target_buffer_pkg::*;

  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] pred_next_pc;
  logic                 pred_taken;
  logic                 upd_valid;
  logic [WORD_SIZE-1:0] upd_pc;
  logic                 upd_is_jump;
  logic                 upd_taken;
  logic [WORD_SIZE-1:0] upd_target;
  logic                 upd_mispredict;
  logic                 busy;
  logic [WORD_SIZE-1:0] mispredict_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_is_jump, upd_taken,
           upd_target, upd_mispredict,
    input  pred_next_pc, pred_taken, busy, mispredict_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_is_jump, upd_taken,
           upd_target, upd_mispredict,
    output pred_next_pc, pred_taken, busy, mispredict_count
  );

endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// sat_counter2
//   Next value of a 2-bit saturating direction counter.
//   ctr_q : current count
//   taken : resolved direction (1 counts up, 0 counts down)
//   ctr_d : next count, held at 0 and 3
module sat_counter2 (
  input  logic [1:0] ctr_q,
  input  logic       taken,
  output logic [1:0] ctr_d
);

  always_comb begin
    ctr_d = ctr_q;
    if (taken && (ctr_q != 2'd3)) begin
      ctr_d = ctr_q + 2'd1;
    end else if (!taken && (ctr_q != 2'd0)) begin
      ctr_d = ctr_q - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped BTB with optional 2-bit direction counters for the IF
//   stage. Lookup is combinational on fetch_pc; EX-stage training writes
//   at the posedge it is presented. After reset the table is cleared one
//   entry per cycle (busy=1) before predictions are enabled.
//   Ports:
//     Clk       : clock, all state on posedge
//     Reset_N   : synchronous active-low reset, restarts table clearing
//     bus       : branch_target_buffer_if.slave (lookup + training + status)
//     state_dbg : current lifecycle state
//   Build option: define BTB_SATURATING_EN for 2-bit direction counters;
//   without it every hit predicts taken and entries only hold targets.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                   Clk,
  input  logic                   Reset_N,
  branch_target_buffer_if.slave  bus,
  output btb_state_e             state_dbg
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;

  btb_state_e                state_q, state_d;
  logic [INDEX_BITS-1:0]     init_ptr_q;
  logic [WORD_SIZE-1:0]      mis_cnt_q;
  logic                      ready;

  logic                      valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]       tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0]      target_q [ENTRIES];
`ifdef BTB_SATURATING_EN
  logic [1:0]                ctr_q    [ENTRIES];
  logic [1:0]                ctr_sat;
  logic [1:0]                ctr_new;
  logic                      ctr_we;
`endif

  // Lifecycle FSM
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      mis_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        init_ptr_q <= init_ptr_q + INDEX_BITS'(1);
      end
      if (ready && bus.upd_valid && bus.upd_mispredict) begin
        mis_cnt_q <= mis_cnt_q + WORD_SIZE'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b1;
    case (state_q)
      INIT:    if (init_ptr_q == PTR_LAST) state_d = READY;
      READY:   bus.busy = 1'b0;
      default: state_d = INIT;
    endcase
  end

  assign ready                = (state_q == READY);
  assign state_dbg            = state_q;
  assign bus.mispredict_count = mis_cnt_q;

  // Lookup
  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0]   f_tag;
  logic                  f_hit;
  logic                  f_taken;

  assign f_idx = bus.fetch_pc[INDEX_BITS-1:0];
  assign f_tag = bus.fetch_pc[WORD_SIZE-1:INDEX_BITS];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
`ifdef BTB_SATURATING_EN
  assign f_taken = f_hit && ctr_q[f_idx][1];
`else
  assign f_taken = f_hit;
`endif

  assign bus.pred_taken   = ready && f_taken;
  assign bus.pred_next_pc = bus.pred_taken ? target_q[f_idx]
                                           : bus.fetch_pc + WORD_SIZE'(1);

  // Training
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit;
  logic                  u_taken;
  logic                  upd_fire;

  assign u_idx    = bus.upd_pc[INDEX_BITS-1:0];
  assign u_tag    = bus.upd_pc[WORD_SIZE-1:INDEX_BITS];
  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_taken  = bus.upd_is_jump || bus.upd_taken;
  assign upd_fire = ready && bus.upd_valid;

`ifdef BTB_SATURATING_EN
  sat_counter2 u_sat (
    .ctr_q (ctr_q[u_idx]),
    .taken (u_taken),
    .ctr_d (ctr_sat)
  );

  // Hits train the counter (jumps pin it strong); taken misses allocate
  // with a jump-dependent starting strength; not-taken misses are dropped.
  assign ctr_we  = upd_fire && (u_hit || u_taken);
  assign ctr_new = bus.upd_is_jump ? CTR_STRONG_TAKEN
                 : (u_hit ? ctr_sat : CTR_WEAK_TAKEN);
`endif

  // A taken outcome writes valid/tag/target whether it hits or allocates;
  // on a hit the tag rewrite is the same value, so one path covers both.
  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      if (!ready) begin
        valid_q[init_ptr_q] <= 1'b0;
      end else if (upd_fire && u_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= bus.upd_target;
      end
    end
  end

`ifdef BTB_SATURATING_EN
  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      if (!ready) begin
        ctr_q[init_ptr_q] <= 2'd0;
      end else if (ctr_we) begin
        ctr_q[u_idx] <= ctr_new;
      end
    end
  end
`endif

endmodule
